led_pattern_sequencer: RTL and testbench

//  Sequences the on-board LED array through a programmable pattern table.

---
 rtl/led_pattern_sequencer.sv | 167 ++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// Steps an LED array through a programmable pattern table with per-step dwell time.
// Optional LED_PWM_EN adds a duty input and 8-bit PWM dimming of led_out during RUN.
module led_pattern_sequencer #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int CNT_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [AW-1:0]    cfg_addr,
   input  logic [WIDTH-1:0] cfg_data,
   input  logic [CNT_W-1:0] dwell,
   input  logic [AW-1:0]    last_idx,
   input  logic             loop_en,
   input  logic             start,
   input  logic             stop,
`ifdef LED_PWM_EN
   input  logic [7:0]       duty,
`endif
   output logic             busy,
   output logic             done,
   output logic [AW-1:0]    step_idx,
   output logic [WIDTH-1:0] led_out
);

   localparam logic [0:0]       ST_IDLE  = 1'b0;
   localparam logic [0:0]       ST_RUN   = 1'b1;
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [AW-1:0]    IDX_ZERO = AW'(0);
   localparam logic [AW-1:0]    IDX_ONE  = AW'(1);
   localparam logic [WIDTH-1:0] PAT_OFF  = WIDTH'(0);

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [AW-1:0]    last_q,  last_d;
   logic             loop_q,  loop_d;
   logic [AW-1:0]    step_q,  step_d;
   logic [WIDTH-1:0] pat_q,   pat_d;
   logic             done_q,  done_d;
   logic [WIDTH-1:0] pat_mem_q [DEPTH];
   logic [WIDTH-1:0] pat_mem_d [DEPTH];

   // Pattern table write port; a same-cycle write never affects the entry being loaded.
   always_comb begin
      pat_mem_d = pat_mem_q;
      if (cfg_we) begin
         pat_mem_d[cfg_addr] = cfg_data;
      end else begin
         pat_mem_d[cfg_addr] = pat_mem_q[cfg_addr];
      end
   end

   // Playback FSM: dwell counting, step advance, loop/one-shot termination and abort.
   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      loop_d  = loop_q;
      step_d  = step_q;
      pat_d   = pat_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               state_d = ST_RUN;
               dwell_d = (dwell == CNT_ZERO) ? CNT_ONE : dwell;
               last_d  = last_idx;
               loop_d  = loop_en;
               step_d  = IDX_ZERO;
               cnt_d   = CNT_ZERO;
               pat_d   = pat_mem_q[IDX_ZERO];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
               step_d  = IDX_ZERO;
               cnt_d   = CNT_ZERO;
               pat_d   = PAT_OFF;
            end else if (cnt_q == dwell_q - CNT_ONE) begin
               cnt_d = CNT_ZERO;
               if (step_q != last_q) begin
                  step_d = step_q + IDX_ONE;
                  pat_d  = pat_mem_q[step_q + IDX_ONE];
               end else if (loop_q) begin
                  step_d = IDX_ZERO;
                  pat_d  = pat_mem_q[IDX_ZERO];
               end else begin
                  state_d = ST_IDLE;
                  step_d  = IDX_ZERO;
                  pat_d   = PAT_OFF;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            step_d  = IDX_ZERO;
            cnt_d   = CNT_ZERO;
            pat_d   = PAT_OFF;
         end
      endcase
   end

   // State and table registers; reset also clears the pattern table.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         dwell_q <= CNT_ZERO;
         cnt_q   <= CNT_ZERO;
         last_q  <= IDX_ZERO;
         loop_q  <= 1'b0;
         step_q  <= IDX_ZERO;
         pat_q   <= PAT_OFF;
         done_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            pat_mem_q[i] <= PAT_OFF;
         end
      end else begin
         state_q   <= state_d;
         dwell_q   <= dwell_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         loop_q    <= loop_d;
         step_q    <= step_d;
         pat_q     <= pat_d;
         done_q    <= done_d;
         pat_mem_q <= pat_mem_d;
      end
   end

   assign busy     = (state_q == ST_RUN);
   assign done     = done_q;
   assign step_idx = step_q;

`ifdef LED_PWM_EN
   logic [7:0] pwm_cnt_q, pwm_cnt_d;

   always_comb begin
      pwm_cnt_d = pwm_cnt_q + 8'd1;
   end

   // Free-running PWM phase counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_cnt_q <= 8'd0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
      end
   end

   // pat_q is already zero outside RUN, so gating it suffices.
   assign led_out = pat_q & {WIDTH{pwm_cnt_q < duty}};
`else
   assign led_out = pat_q;
`endif

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer: the driver queues expected outputs
// tagged by cycle number, a negedge monitor pops and compares them.
module tb_led_pattern_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [2:0]  cfg_data;
   logic [23:0] dwell;
   logic [2:0]  last_idx;
   logic        loop_en;
   logic        start;
   logic        stop;
   logic        busy;
   logic        done;
   logic [2:0]  step_idx;
   logic [2:0]  led_out;
`ifdef LED_PWM_EN
   logic [7:0]  duty = 8'd255;
`endif

   led_pattern_sequencer dut (
      .clk      (clk),
      .reset    (reset),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .dwell    (dwell),
      .last_idx (last_idx),
      .loop_en  (loop_en),
      .start    (start),
      .stop     (stop),
`ifdef LED_PWM_EN
      .duty     (duty),
`endif
      .busy     (busy),
      .done     (done),
      .step_idx (step_idx),
      .led_out  (led_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic       busy;
      logic       done;
      logic [2:0] step;
      logic [2:0] led;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;
   exp_t mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation whose cycle has come.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         mon_e = exp_q.pop_front();
         n_chk++;
         if (mon_e.cyc == cyc && busy === mon_e.busy && done === mon_e.done &&
             step_idx === mon_e.step && led_out === mon_e.led) begin
            n_pass++;
         end else begin
            $display("FAIL %s cyc=%0d(exp %0d): got busy=%b done=%b step=%0d led=%b, want busy=%b done=%b step=%0d led=%b",
                     mon_e.name, cyc, mon_e.cyc, busy, done, step_idx, led_out,
                     mon_e.busy, mon_e.done, mon_e.step, mon_e.led);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_e(input int c, input logic b, input logic d, input logic [2:0] s,
                         input logic [2:0] l, input string nm);
      exp_t e;
      e.cyc = c; e.busy = b; e.done = d; e.step = s; e.led = l; e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic push_steps(input int c, input logic [2:0] s, input logic [2:0] l,
                             input int n, input string nm);
      for (int i = 0; i < n; i++) push_e(c + i, 1'b1, 1'b0, s, l, nm);
   endtask

   task automatic push_idle(input int c, input int n, input string nm);
      for (int i = 0; i < n; i++) push_e(c + i, 1'b0, 1'b0, 3'd0, 3'b000, nm);
   endtask

   task automatic write_pat(input logic [2:0] a, input logic [2:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic cfg_run(input logic [23:0] dw, input logic [2:0] li, input logic le);
      dwell = dw; last_idx = li; loop_en = le;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() > 0 && t < 60) begin
         tick();
         t++;
      end
      if (exp_q.size() > 0) begin
         n_chk++;
         $display("FAIL drain_timeout: got %0d pending expectations, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   int c0;
   logic [2:0] lut [3];

   initial begin
      lut[0] = 3'b001; lut[1] = 3'b010; lut[2] = 3'b100;
      reset = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 3'd0;
      dwell = 24'd0; last_idx = 3'd0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
      push_idle(1, 2, "reset_state");
      tick(); tick();
      reset = 1'b0;
      drain();

      write_pat(3'd0, 3'b001);
      write_pat(3'd1, 3'b010);
      write_pat(3'd2, 3'b100);

      // 1: one-shot, dwell 4
      cfg_run(24'd4, 3'd2, 1'b0);
      c0 = cyc; start = 1'b1;
      push_steps(c0 + 1, 3'd0, 3'b001, 4, "oneshot_s0");
      push_steps(c0 + 5, 3'd1, 3'b010, 4, "oneshot_s1");
      push_steps(c0 + 9, 3'd2, 3'b100, 4, "oneshot_s2");
      push_e(c0 + 13, 1'b0, 1'b1, 3'd0, 3'b000, "oneshot_done");
      push_idle(c0 + 14, 2, "oneshot_after");
      tick(); start = 1'b0;
      drain();

      // 2: looped, 30 cycles, then stop
      cfg_run(24'd4, 3'd2, 1'b1);
      c0 = cyc; start = 1'b1;
      for (int i = 0; i < 30; i++)
         push_e(c0 + 1 + i, 1'b1, 1'b0, 3'((i / 4) % 3), lut[(i / 4) % 3], "loop_seq");
      push_idle(c0 + 31, 2, "loop_stop");
      tick(); start = 1'b0;
      repeat (29) tick();
      stop = 1'b1; tick(); stop = 1'b0;
      drain();

      // 3: stop on cycle 6 of a one-shot run
      cfg_run(24'd4, 3'd2, 1'b0);
      c0 = cyc; start = 1'b1;
      push_steps(c0 + 1, 3'd0, 3'b001, 4, "stop_s0");
      push_steps(c0 + 5, 3'd1, 3'b010, 2, "stop_s1");
      push_idle(c0 + 7, 10, "stop_idle_no_done");
      tick(); start = 1'b0;
      repeat (5) tick();
      stop = 1'b1; tick(); stop = 1'b0;
      drain();

      // 4a: start+stop together in IDLE
      c0 = cyc; start = 1'b1; stop = 1'b1;
      push_idle(c0 + 1, 3, "start_stop_idle");
      tick(); start = 1'b0; stop = 1'b0;
      drain();

      // 4b: start re-asserted during RUN is ignored
      c0 = cyc; start = 1'b1;
      push_steps(c0 + 1, 3'd0, 3'b001, 4, "rerun_s0");
      push_steps(c0 + 5, 3'd1, 3'b010, 4, "rerun_s1");
      push_steps(c0 + 9, 3'd2, 3'b100, 4, "rerun_s2");
      push_e(c0 + 13, 1'b0, 1'b1, 3'd0, 3'b000, "rerun_done");
      push_idle(c0 + 14, 1, "rerun_after");
      tick(); start = 1'b0;
      repeat (4) tick();
      start = 1'b1; tick(); start = 1'b0;
      drain();

      // 5: dwell 0 behaves as 1, single step
      write_pat(3'd0, 3'b111);
      cfg_run(24'd0, 3'd0, 1'b0);
      c0 = cyc; start = 1'b1;
      push_e(c0 + 1, 1'b1, 1'b0, 3'd0, 3'b111, "dwell0_show");
      push_e(c0 + 2, 1'b0, 1'b1, 3'd0, 3'b000, "dwell0_done");
      push_idle(c0 + 3, 1, "dwell0_after");
      tick(); start = 1'b0;
      drain();

      // 6: reset mid-run in step 1, then table must read back as zeros
      write_pat(3'd0, 3'b001);
      cfg_run(24'd4, 3'd2, 1'b0);
      c0 = cyc; start = 1'b1;
      push_steps(c0 + 1, 3'd0, 3'b001, 4, "rst_s0");
      push_steps(c0 + 5, 3'd1, 3'b010, 2, "rst_s1");
      push_idle(c0 + 7, 1, "rst_outputs");
      push_steps(c0 + 8, 3'd0, 3'b000, 1, "rst_cleared0");
      push_steps(c0 + 9, 3'd1, 3'b000, 1, "rst_cleared1");
      push_steps(c0 + 10, 3'd2, 3'b000, 1, "rst_cleared2");
      push_e(c0 + 11, 1'b0, 1'b1, 3'd0, 3'b000, "rst_clear_done");
      tick(); start = 1'b0;
      repeat (5) tick();
      reset = 1'b1; tick(); reset = 1'b0;
      cfg_run(24'd1, 3'd2, 1'b0);
      start = 1'b1; tick(); start = 1'b0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
